// File: rtl/vigna_prefetch_if.sv
// Bus and core-side signal bundle for the vigna instruction prefetch queue.
// "master" is the prefetcher's view; "slave" is the view of the bus/core around it.
interface vigna_prefetch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              i_valid;
    logic              i_ready;
    logic [31:0]       i_addr;
    logic [31:0]       i_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output i_valid, i_addr, inst_valid, inst_data, inst_pc, fifo_level,
        input  i_ready, i_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  i_valid, i_addr, inst_valid, inst_data, inst_pc, fifo_level,
        output i_ready, i_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/vigna_prefetch.sv
// Instruction prefetch queue: keeps at most one bus read in flight and buffers
// fetched {pc, data} words in a circular queue until the core consumes them.
module vigna_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             resetn,
    vigna_prefetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       fp_q, fp_d;
    logic              discard_q, discard_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic              done;
    logic              pop;
    logic              push;
    logic              busy_next;
    logic [31:0]       target;
    logic [31:0]       fp_eff;

    always_comb begin
        done      = req_q & bus.i_ready;
        pop       = (level_q != '0) & bus.inst_ready;
        push      = done & ~bus.redirect & ~discard_q;
        busy_next = req_q & ~done;
        target    = {bus.redirect_pc[31:2], 2'b00};

        head_d    = head_q;
        tail_d    = tail_q;
        level_d   = level_q;
        discard_d = discard_q;
        fp_eff    = fp_q;

        if (bus.redirect) begin
            // A still-outstanding read must run to completion, so mark its data as stale.
            level_d   = '0;
            head_d    = tail_q;
            fp_eff    = target;
            discard_d = busy_next;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
            if (done) discard_d = 1'b0;
        end

        req_d  = req_q;
        addr_d = addr_q;
        fp_d   = fp_eff;
        // Only issue when the queue has room for the returning word.
        if (!busy_next) begin
            if (level_d < LVL_W'(DEPTH)) begin
                req_d  = 1'b1;
                addr_d = fp_eff;
                fp_d   = fp_eff + 32'd4;
            end else begin
                req_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q     <= 1'b0;
            addr_q    <= RESET_ADDR;
            fp_q      <= RESET_ADDR;
            discard_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            fp_q      <= fp_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= addr_q;
            data_mem[tail_q] <= bus.i_rdata;
        end
    end

    assign bus.i_valid    = req_q;
    assign bus.i_addr     = addr_q;
    assign bus.inst_valid = (level_q != '0);
    assign bus.inst_data  = data_mem[head_q];
    assign bus.inst_pc    = pc_mem[head_q];
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_vigna_prefetch.sv
// Bench for vigna_prefetch: directed scenarios on a DEPTH=4 instance, then
// randomized bus/core traffic on DEPTH=2 and DEPTH=16 instances against a program-order model.
module tb_vigna_prefetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic rnd_en;
    int   tests = 0;
    int   fails = 0;
    int   redirs [2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vigna_prefetch_if #(.DEPTH(4)) d4 ();
    vigna_prefetch #(.DEPTH(4), .RESET_ADDR(32'h0)) u_d4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (d4.master)
    );
    assign d4.i_rdata = mem_word(d4.i_addr);

    // Random-traffic instances: each has its own slave, core and reference model.
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int D = (g == 0) ? 2 : 16;
        vigna_prefetch_if #(.DEPTH(D)) rb ();
        vigna_prefetch #(.DEPTH(D), .RESET_ADDR(32'h0)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (rb.master)
        );

        logic [31:0] exp_pc;
        logic [31:0] held_addr;
        logic [31:0] r;
        logic [31:0] tgt;
        logic        armed;
        int          lat;

        initial begin
            rb.i_ready     = 1'b0;
            rb.i_rdata     = 32'h0;
            rb.inst_ready  = 1'b0;
            rb.redirect    = 1'b0;
            rb.redirect_pc = 32'h0;
        end

        always @(negedge clk) begin
            if (!rnd_en || !resetn) begin
                rb.i_ready    = 1'b0;
                rb.inst_ready = 1'b0;
                rb.redirect   = 1'b0;
                exp_pc        = 32'h0;
                armed         = 1'b0;
                lat           = 0;
                redirs[g]     = 0;
            end else begin
                check($sformatf("rnd%0d_level_bound", D), 32'(rb.fifo_level <= D), 32'd1);
                check($sformatf("rnd%0d_inst_valid", D), 32'(rb.inst_valid), 32'(rb.fifo_level != 0));
                rb.i_ready = 1'b0;
                if (rb.i_valid) begin
                    if (!armed) begin
                        armed     = 1'b1;
                        lat       = $urandom_range(0, 5);
                        held_addr = rb.i_addr;
                    end else begin
                        check($sformatf("rnd%0d_addr_hold", D), rb.i_addr, held_addr);
                    end
                    if (lat == 0) begin
                        rb.i_ready = 1'b1;
                        rb.i_rdata = mem_word(rb.i_addr);
                        armed      = 1'b0;
                    end else begin
                        lat--;
                    end
                end
                rb.inst_ready = ($urandom_range(0, 3) != 0);
                rb.redirect   = ($urandom_range(0, 7) == 0);
                if (rb.redirect) begin
                    r   = $urandom;
                    tgt = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, r[3:0]} : r;
                    rb.redirect_pc = tgt;
                    exp_pc = {tgt[31:2], 2'b00};
                    redirs[g]++;
                end else if (rb.inst_valid && rb.inst_ready) begin
                    check($sformatf("rnd%0d_pc", D), rb.inst_pc, exp_pc);
                    check($sformatf("rnd%0d_data", D), rb.inst_data, mem_word(exp_pc));
                    exp_pc += 32'd4;
                end
            end
        end
    end

    initial begin
        logic [31:0] e;
        int          got;
        int          gaps;
        int          ncomp;
        bit          seen;

        resetn         = 1'b0;
        rnd_en         = 1'b0;
        d4.i_ready     = 1'b0;
        d4.inst_ready  = 1'b0;
        d4.redirect    = 1'b0;
        d4.redirect_pc = 32'h0;
        @(negedge clk);
        tick();
        tick();

        check("rst_i_valid",    32'(d4.i_valid),    32'd0);
        check("rst_i_addr",     d4.i_addr,          32'h0);
        check("rst_fifo_level", 32'(d4.fifo_level), 32'd0);
        check("rst_inst_valid", 32'(d4.inst_valid), 32'd0);

        // Continuous streaming from reset
        d4.i_ready    = 1'b1;
        d4.inst_ready = 1'b1;
        resetn        = 1'b1;
        tick();
        check("first_i_valid", 32'(d4.i_valid), 32'd1);
        check("first_i_addr",  d4.i_addr,       32'h0);
        e = 32'h0; got = 0; gaps = 0; seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (d4.inst_valid) begin
                check("stream_pc",   d4.inst_pc,   e);
                check("stream_data", d4.inst_data, mem_word(e));
                e += 32'd4;
                got++;
                seen = 1'b1;
            end else if (seen) begin
                gaps++;
            end
            tick();
        end
        check("stream_count", 32'(got),  32'd23);
        check("stream_gaps",  32'(gaps), 32'd0);

        // Core stalled: queue fills, fetching stops, then resumes
        resetn = 1'b0; d4.inst_ready = 1'b0;
        tick();
        resetn = 1'b1;
        ncomp = 0;
        for (int c = 0; c < 12; c++) begin
            if (d4.i_valid && d4.i_ready) ncomp++;
            tick();
        end
        check("stall_completions", 32'(ncomp),         32'd4);
        check("stall_level",       32'(d4.fifo_level), 32'd4);
        check("stall_i_valid",     32'(d4.i_valid),    32'd0);
        check("stall_inst_valid",  32'(d4.inst_valid), 32'd1);
        check("stall_head_pc",     d4.inst_pc,         32'h0);
        check("stall_head_data",   d4.inst_data,       mem_word(32'h0));
        d4.inst_ready = 1'b1;
        tick();
        check("resume_i_valid", 32'(d4.i_valid),    32'd1);
        check("resume_i_addr",  d4.i_addr,          32'h10);
        check("resume_level",   32'(d4.fifo_level), 32'd3);
        check("resume_head_pc", d4.inst_pc,         32'h4);

        // Redirect while the bus slave stalls
        resetn = 1'b0; d4.inst_ready = 1'b0; d4.i_ready = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("rd_pre_valid", 32'(d4.i_valid), 32'd1);
        check("rd_pre_addr",  d4.i_addr,       32'h0);
        d4.redirect = 1'b1; d4.redirect_pc = 32'h103;
        tick();
        d4.redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rd_hold_valid", 32'(d4.i_valid), 32'd1);
            check("rd_hold_addr",  d4.i_addr,       32'h0);
            tick();
        end
        check("rd_hold_addr_last", d4.i_addr, 32'h0);
        d4.i_ready = 1'b1;
        tick();
        check("rd_drop_level", 32'(d4.fifo_level), 32'd0);
        check("rd_new_valid",  32'(d4.i_valid),    32'd1);
        check("rd_new_addr",   d4.i_addr,          32'h100);
        tick();
        check("rd_first_valid", 32'(d4.inst_valid), 32'd1);
        check("rd_first_pc",    d4.inst_pc,         32'h100);
        check("rd_first_data",  d4.inst_data,       mem_word(32'h100));
        check("rd_next_addr",   d4.i_addr,          32'h104);

        // Redirect coinciding with a pop and a completion at level 2
        resetn = 1'b0; d4.i_ready = 1'b0; d4.inst_ready = 1'b0;
        tick();
        resetn = 1'b1; d4.i_ready = 1'b1;
        tick(); tick(); tick();
        check("pri_pre_level", 32'(d4.fifo_level), 32'd2);
        check("pri_pre_addr",  d4.i_addr,          32'h8);
        d4.inst_ready = 1'b1; d4.redirect = 1'b1; d4.redirect_pc = 32'h200;
        tick();
        d4.redirect = 1'b0;
        check("pri_level",      32'(d4.fifo_level), 32'd0);
        check("pri_inst_valid", 32'(d4.inst_valid), 32'd0);
        check("pri_i_addr",     d4.i_addr,          32'h200);
        e = 32'h200; got = 0;
        for (int c = 0; c < 10; c++) begin
            if (d4.inst_valid) begin
                check("pri_pc",   d4.inst_pc,   e);
                check("pri_data", d4.inst_data, mem_word(e));
                e += 32'd4;
                got++;
            end
            tick();
        end
        check("pri_count", 32'(got), 32'd9);

        // Fetch pointer wrap at the top of the address space
        d4.redirect = 1'b1; d4.redirect_pc = 32'hFFFF_FFFA;
        tick();
        d4.redirect = 1'b0;
        e = 32'hFFFF_FFF8; got = 0;
        for (int c = 0; c < 6; c++) begin
            if (d4.inst_valid) begin
                check("wrap_pc",   d4.inst_pc,   e);
                check("wrap_data", d4.inst_data, mem_word(e));
                e += 32'd4;
                got++;
            end
            tick();
        end
        check("wrap_count", 32'(got), 32'd5);

        // Randomized traffic on the DEPTH=2 and DEPTH=16 instances
        resetn = 1'b0; rnd_en = 1'b1;
        tick(); tick();
        resetn = 1'b1;
        for (int c = 0; c < 60000 && !(redirs[0] >= 1000 && redirs[1] >= 1000); c++) tick();
        check("rnd_redirects_d2",  32'(redirs[0] >= 1000), 32'd1);
        check("rnd_redirects_d16", 32'(redirs[1] >= 1000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
